add_unit_scheduler: RTL and testbench
=====================================

# add_unit_scheduler

Schedules the shared 32-bit integer adder of the Tomasulo add/sub functional unit among the add reservation stations. Arbitrates round-robin between ready stations, registers the chosen operands into the adder, and captures the 33-bit result with its tag. Presents the result to the common data bus (CDB) through a request/grant handshake, with backpressure and flush. Sits between the add reservation stations and the CDB arbiter; the adder itself is instantiated externally and connected through the `add_*` ports.

## Interface

- `NUM_RS`, 3: number of requesting reservation stations (2..8).
- `WIDTH`, 32: operand width.
- `TAG_W`, 4: reservation-station tag width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rs_req`  in  NUM_RS  station i has both operands ready.
- `rs_tag`  in  NUM_RS*TAG_W  station i tag in slice [i*TAG_W +: TAG_W].
- `rs_a`, `rs_b`  in  NUM_RS*WIDTH  station i operands, sliced likewise.
- `rs_gnt`  out  NUM_RS  one-hot accept, combinational; station drops `rs_req` after the accepting edge.
- `flush`  in  1  synchronous kill of all in-flight operations.
- `add_a`, `add_b`  out  WIDTH  operands to external adder (stage-1 registers).
- `add_sum`  in  WIDTH+1  adder result, MSB is carry-out.
- `cdb_req`  out  1  result valid, request CDB.
- `cdb_gnt`  in  1  CDB accepts result this cycle.
- `cdb_tag`  out  TAG_W  tag of result.
- `cdb_data`  out  WIDTH  sum[WIDTH-1:0].
- `cdb_carry`  out  1  sum[WIDTH].
- `occupancy`  out  2  in-flight count (0..2).

## Operation

- Two pipeline registers: S1 {v1, tag1, a1, b1}, S2 {v2, tag2, sum2}. `add_a`=a1, `add_b`=b1; adder is purely combinational between S1 and S2.
- Advance rules, evaluated each cycle:
  - s2_free = !v2 || cdb_gnt.
  - s1_move = v1 && s2_free.
  - s1_free = !v1 || s1_move.
- Arbitration: when s1_free && !flush && |rs_req, grant the first requesting index scanning rr_ptr, rr_ptr+1, … mod NUM_RS. Otherwise rs_gnt = 0.
- On grant to i: S1 loads station i tag/operands, v1 <= 1, rr_ptr <= (i+1) mod NUM_RS. Without grant and with s1_move: v1 <= 0.
- On s1_move: S2 loads tag1 and add_sum, v2 <= 1. Else if cdb_gnt && v2: v2 <= 0.
- cdb_req = v2. cdb_tag/data/carry = S2 contents, held stable while cdb_req && !cdb_gnt.
- cdb_gnt while !v2 is ignored.
- flush: v1 <= 0, v2 <= 0 at that edge, no grant that cycle, rr_ptr unchanged. A cdb_gnt in the same cycle still completes the current transfer.
- occupancy = v1 + v2.
- Arithmetic: unsigned 33-bit sum, no overflow detection, no subtract (stations pre-negate).

## Timing

- Reset (async assert, sync-safe release): v1=v2=0, rr_ptr=0, S1/S2 data=0. All outputs 0: rs_gnt, cdb_*, add_a, add_b, occupancy.
- Latency: grant in cycle C → S1 valid in C+1 (adder evaluates) → cdb_req high in C+2. Minimum C to CDB transfer is 2 cycles.
- Throughput: one grant per cycle while cdb_gnt is held high.
- Full stall: v1 && v2 && !cdb_gnt → rs_gnt=0, both stages hold.
- Stall release: cdb_gnt with both stages full → same edge S2 <= S1, S1 <= new grant if any. Zero bubbles.
- Reset mid-operation: in-flight results are discarded; no cdb_req until new grants.

## Test plan

- Single op: rs_req[0], a=000FF00E, b=00000070, cdb_gnt=1. Required: gnt[0] at C; cdb_req at C+2 with data=000FF07E, carry=0, matching tag.
- Carry: a=F00F8C05, b=10A13206. Required: data=00B0BE0B, carry=1. Also a=AAAAAAAA, b=55555555 gives FFFFFFFF, carry=0.
- Round-robin: all 3 requests held continuously, cdb_gnt=1. Required: grants 0,1,2,0,… on consecutive cycles, results in the same order, one per cycle.
- Backpressure: cdb_gnt=0 for 5 cycles with continuous requests. Required: occupancy reaches 2, rs_gnt=0, cdb outputs stable. After cdb_gnt=1, in-order drain with no loss or duplication.
- Flush: flush with occupancy=2. Required: next cycle occupancy=0, cdb_req=0, no grant in the flush cycle, rr_ptr preserved.
- Reset: assert rst_n=0 asynchronously mid-stream. Required: all outputs 0 immediately. First grant after release goes to station 0.

Source files
------------

// File: rtl/add_unit_scheduler.sv
// Issue scheduler for the shared add/sub adder: round-robin pick among ready
// reservation stations, two-stage operand/result pipeline, CDB request/grant.
module add_unit_scheduler #(
  parameter int NUM_RS = 3,
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_RS-1:0]         rs_req,
  input  logic [NUM_RS*TAG_W-1:0]   rs_tag,
  input  logic [NUM_RS*WIDTH-1:0]   rs_a,
  input  logic [NUM_RS*WIDTH-1:0]   rs_b,
  output logic [NUM_RS-1:0]         rs_gnt,
  input  logic                      flush,
  output logic [WIDTH-1:0]          add_a,
  output logic [WIDTH-1:0]          add_b,
  input  logic [WIDTH:0]            add_sum,
  output logic                      cdb_req,
  input  logic                      cdb_gnt,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [WIDTH-1:0]          cdb_data,
  output logic                      cdb_carry,
  output logic [1:0]                occupancy
);

  localparam int PTR_W = $clog2(NUM_RS);
  localparam logic [PTR_W:0]   NUM_RS_W = (PTR_W+1)'(NUM_RS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_RS - 1);

  logic                v1_r, v2_r;
  logic [PTR_W-1:0]    rr_ptr_r;
  logic [TAG_W-1:0]    tag1_r, tag2_r;
  logic [WIDTH-1:0]    a1_r, b1_r;
  logic [WIDTH:0]      sum2_r;

  logic                s2_free_s, s1_move_s, s1_free_s;
  logic [2*NUM_RS-1:0] req_dbl_s, req_rot_s;
  logic                found_s, grant_s;
  logic [PTR_W-1:0]    gnt_idx_s, rr_next_s;
  logic [PTR_W:0]      cand_s, wrap_s;
  logic [NUM_RS-1:0]   gnt_oh_s;
  logic [TAG_W-1:0]    sel_tag_s;
  logic [WIDTH-1:0]    sel_a_s, sel_b_s;

  assign s2_free_s = !v2_r || cdb_gnt;
  assign s1_move_s = v1_r && s2_free_s;
  assign s1_free_s = !v1_r || s1_move_s;

  // Rotating the doubled request vector puts rr_ptr at bit 0, so the scan order is fixed.
  assign req_dbl_s = {rs_req, rs_req};
  assign req_rot_s = req_dbl_s >> rr_ptr_r;

  // Round-robin search: first requester at or after rr_ptr, index wrapped mod NUM_RS.
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = '0;
    cand_s    = '0;
    wrap_s    = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      cand_s    = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      wrap_s    = (cand_s >= NUM_RS_W) ? (cand_s - NUM_RS_W) : cand_s;
      gnt_idx_s = (!found_s && req_rot_s[k]) ? wrap_s[PTR_W-1:0] : gnt_idx_s;
      found_s   = found_s | req_rot_s[k];
    end
  end

  // Reset gates the grant so every output reads zero while rst_n is low.
  assign grant_s   = s1_free_s && !flush && found_s && rst_n;
  assign gnt_oh_s  = {{(NUM_RS-1){1'b0}}, 1'b1} << gnt_idx_s;
  assign rr_next_s = (gnt_idx_s == LAST_IDX) ? '0 : (gnt_idx_s + PTR_W'(1));

  // Drive the one-hot accept only on a cycle where stage 1 can take a new operation.
  always_comb begin
    if (grant_s) begin
      rs_gnt = gnt_oh_s;
    end else begin
      rs_gnt = '0;
    end
  end

  // AND-OR mux of the selected station's tag and operands.
  always_comb begin
    sel_tag_s = '0;
    sel_a_s   = '0;
    sel_b_s   = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      sel_tag_s = sel_tag_s | (rs_tag[i*TAG_W +: TAG_W] & {TAG_W{gnt_oh_s[i]}});
      sel_a_s   = sel_a_s   | (rs_a[i*WIDTH +: WIDTH]   & {WIDTH{gnt_oh_s[i]}});
      sel_b_s   = sel_b_s   | (rs_b[i*WIDTH +: WIDTH]   & {WIDTH{gnt_oh_s[i]}});
    end
  end

  // Stage 1: operand registers feeding the external adder, plus the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r     <= 1'b0;
      rr_ptr_r <= '0;
      tag1_r   <= '0;
      a1_r     <= '0;
      b1_r     <= '0;
    end else if (flush) begin
      v1_r <= 1'b0;
    end else if (grant_s) begin
      v1_r     <= 1'b1;
      rr_ptr_r <= rr_next_s;
      tag1_r   <= sel_tag_s;
      a1_r     <= sel_a_s;
      b1_r     <= sel_b_s;
    end else if (s1_move_s) begin
      v1_r <= 1'b0;
    end else begin
      v1_r <= v1_r;
    end
  end

  // Stage 2: result register held stable toward the CDB until granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      tag2_r <= '0;
      sum2_r <= '0;
    end else if (flush) begin
      v2_r <= 1'b0;
    end else if (s1_move_s) begin
      v2_r   <= 1'b1;
      tag2_r <= tag1_r;
      sum2_r <= add_sum;
    end else if (cdb_gnt && v2_r) begin
      v2_r <= 1'b0;
    end else begin
      v2_r <= v2_r;
    end
  end

  assign add_a     = a1_r;
  assign add_b     = b1_r;
  assign cdb_req   = v2_r;
  assign cdb_tag   = tag2_r;
  assign cdb_data  = sum2_r[WIDTH-1:0];
  assign cdb_carry = sum2_r[WIDTH];
  assign occupancy = {1'b0, v1_r} + {1'b0, v2_r};

endmodule

// File: tb/tb_add_unit_scheduler.sv
// Directed bench for add_unit_scheduler: queue-based pipeline model checked every
// cycle, plus hand-computed expectations for sums, grant order, flush and reset.
module tb_add_unit_scheduler;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int TW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      rs_req;
  logic [N*TW-1:0]   rs_tag;
  logic [N*W-1:0]    rs_a, rs_b;
  logic [N-1:0]      rs_gnt;
  logic              flush;
  logic [W-1:0]      add_a, add_b;
  logic [W:0]        add_sum;
  logic              cdb_req, cdb_gnt;
  logic [TW-1:0]     cdb_tag;
  logic [W-1:0]      cdb_data;
  logic              cdb_carry;
  logic [1:0]        occupancy;

  logic [TW-1:0]     tagv [N];
  logic [W-1:0]      av [N];
  logic [W-1:0]      bv [N];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W:0]    sum;
    logic          st2;
  } op_t;

  op_t pipe [$];
  int  mrr     = 0;
  int  last_gi = -1;
  bit  hold_req = 1'b0;

  add_unit_scheduler #(.NUM_RS(N), .WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .rs_req(rs_req), .rs_tag(rs_tag), .rs_a(rs_a), .rs_b(rs_b),
    .rs_gnt(rs_gnt), .flush(flush), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_carry(cdb_carry), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // The external adder the scheduler drives.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  always_comb begin
    rs_tag = '0;
    rs_a   = '0;
    rs_b   = '0;
    for (int i = 0; i < N; i++) begin
      rs_tag[i*TW +: TW] = tagv[i];
      rs_a[i*W +: W]     = av[i];
      rs_b[i*W +: W]     = bv[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: ordered list of in-flight ops; head may sit in the output slot (st2).
  task automatic predict(output logic pv1, output logic pv2, output int pgi);
    logic can_take;
    pv2 = (pipe.size() > 0) && pipe[0].st2;
    pv1 = (pipe.size() > 0) && !pipe[pipe.size()-1].st2;
    can_take = !pv1 || !pv2 || cdb_gnt;
    pgi = -1;
    if (rst_n && can_take && !flush) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mrr + k) % N;
        if (rs_req[j] && pgi < 0) pgi = j;
      end
    end
  endtask

  task automatic model_update();
    logic pv1, pv2;
    int   pgi;
    op_t  h;
    last_gi = -1;
    if (!rst_n) begin
      pipe.delete();
      mrr = 0;
      return;
    end
    predict(pv1, pv2, pgi);
    if (flush) begin
      pipe.delete();
      return;
    end
    if (pv2 && cdb_gnt) h = pipe.pop_front();
    if (pipe.size() > 0 && !pipe[0].st2) begin
      h = pipe.pop_front();
      h.st2 = 1'b1;
      pipe.push_front(h);
    end
    if (pgi >= 0) begin
      h.tag = tagv[pgi];
      h.a   = av[pgi];
      h.b   = bv[pgi];
      h.sum = {1'b0, av[pgi]} + {1'b0, bv[pgi]};
      h.st2 = 1'b0;
      pipe.push_back(h);
      mrr = (pgi + 1) % N;
      last_gi = pgi;
    end
  endtask

  task automatic compare_all();
    logic pv1, pv2;
    int   pgi;
    logic [N-1:0] g;
    if (!rst_n) return;
    predict(pv1, pv2, pgi);
    g = (pgi >= 0) ? (3'b001 << pgi) : 3'b000;
    chk("gnt", 64'(rs_gnt), 64'(g));
    chk("cdb_req", 64'(cdb_req), 64'(pv2));
    chk("occupancy", 64'(occupancy), 64'(pipe.size()));
    if (pv2) begin
      chk("cdb_tag", 64'(cdb_tag), 64'(pipe[0].tag));
      chk("cdb_data", 64'(cdb_data), 64'(pipe[0].sum[W-1:0]));
      chk("cdb_carry", 64'(cdb_carry), 64'(pipe[0].sum[W]));
    end
    if (pv1) begin
      chk("add_a", 64'(add_a), 64'(pipe[pipe.size()-1].a));
      chk("add_b", 64'(add_b), 64'(pipe[pipe.size()-1].b));
    end
  endtask

  // One cycle: check at the falling edge, advance the model at the rising edge.
  task automatic edge_tail();
    @(posedge clk);
    model_update();
    #1;
    if (!hold_req && last_gi >= 0) rs_req[last_gi] = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    edge_tail();
  endtask

  task automatic run_op(input int idx, input logic [TW-1:0] t, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_d, input logic exp_c);
    logic [N-1:0] oh;
    tagv[idx] = t;
    av[idx]   = a;
    bv[idx]   = b;
    rs_req[idx] = 1'b1;
    cdb_gnt = 1'b1;
    oh = 3'b001 << idx;
    #1;
    chk("op_gnt", 64'(rs_gnt), 64'(oh));
    tick();
    tick();
    chk("op_req", 64'(cdb_req), 64'(1'b1));
    chk("op_data", 64'(cdb_data), 64'(exp_d));
    chk("op_carry", 64'(cdb_carry), 64'(exp_c));
    chk("op_tag", 64'(cdb_tag), 64'(t));
    tick();
  endtask

  int exp_seq [6] = '{1, 2, 0, 1, 2, 0};

  initial begin
    logic [N-1:0] oh;
    rst_n   = 1'b0;
    rs_req  = '0;
    flush   = 1'b0;
    cdb_gnt = 1'b0;
    for (int i = 0; i < N; i++) begin
      tagv[i] = '0;
      av[i]   = '0;
      bv[i]   = '0;
    end
    #1;
    chk("reset_gnt", 64'(rs_gnt), 64'(3'b000));
    chk("reset_cdb_req", 64'(cdb_req), 64'(1'b0));
    chk("reset_occ", 64'(occupancy), 64'(2'd0));
    chk("reset_add_a", 64'(add_a), 64'(32'h0));
    chk("reset_cdb_data", 64'(cdb_data), 64'(32'h0));
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operations, including carry-out.
    run_op(0, 4'h1, 32'h000FF00E, 32'h00000070, 32'h000FF07E, 1'b0);
    run_op(0, 4'h2, 32'hF00F8C05, 32'h10A13206, 32'h00B0BE0B, 1'b1);
    run_op(0, 4'h3, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0);

    // Round-robin with all stations requesting; pointer sits at 1 after the ops above.
    tagv[0] = 4'h5; av[0] = 32'd100; bv[0] = 32'd1;
    tagv[1] = 4'h6; av[1] = 32'd200; bv[1] = 32'd2;
    tagv[2] = 4'h7; av[2] = 32'd300; bv[2] = 32'hFFFFFFFF;
    hold_req = 1'b1;
    rs_req   = 3'b111;
    cdb_gnt  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      oh = 3'b001 << exp_seq[k];
      chk("rr_gnt", 64'(rs_gnt), 64'(oh));
      if (k >= 2) begin
        chk("rr_req", 64'(cdb_req), 64'(1'b1));
        chk("rr_tag", 64'(cdb_tag), 64'(tagv[exp_seq[k-2]]));
      end
      tick();
    end

    // Backpressure: both stages fill and hold.
    cdb_gnt = 1'b0;
    repeat (5) tick();
    chk("bp_occ", 64'(occupancy), 64'(2'd2));
    chk("bp_gnt", 64'(rs_gnt), 64'(3'b000));
    chk("bp_tag", 64'(cdb_tag), 64'(4'h7));
    chk("bp_data", 64'(cdb_data), 64'(32'd299));
    chk("bp_carry", 64'(cdb_carry), 64'(1'b1));
    cdb_gnt = 1'b1;
    tick();
    chk("drain_tag", 64'(cdb_tag), 64'(4'h5));
    rs_req = '0;
    repeat (3) tick();
    chk("drain_occ", 64'(occupancy), 64'(2'd0));

    // Flush with both stages full; pointer is 2, stations 0/1 requesting.
    rs_req  = 3'b011;
    cdb_gnt = 1'b0;
    tick();
    tick();
    chk("fl_occ_before", 64'(occupancy), 64'(2'd2));
    flush = 1'b1;
    #1;
    chk("fl_gnt", 64'(rs_gnt), 64'(3'b000));
    tick();
    flush = 1'b0;
    #1;
    chk("fl_occ_after", 64'(occupancy), 64'(2'd0));
    chk("fl_cdb_req", 64'(cdb_req), 64'(1'b0));
    chk("fl_next_gnt", 64'(rs_gnt), 64'(3'b001));
    cdb_gnt = 1'b1;
    tick();

    // Asynchronous reset in the middle of a stream.
    rs_req = 3'b111;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", 64'(rs_gnt), 64'(3'b000));
    chk("ar_cdb_req", 64'(cdb_req), 64'(1'b0));
    chk("ar_occ", 64'(occupancy), 64'(2'd0));
    chk("ar_add_a", 64'(add_a), 64'(32'h0));
    chk("ar_add_b", 64'(add_b), 64'(32'h0));
    chk("ar_cdb_tag", 64'(cdb_tag), 64'(4'h0));
    chk("ar_cdb_data", 64'(cdb_data), 64'(32'h0));
    chk("ar_cdb_carry", 64'(cdb_carry), 64'(1'b0));
    model_update();
    #2 rst_n = 1'b1;
    #1;
    chk("ar_first_gnt", 64'(rs_gnt), 64'(3'b001));
    edge_tail();
    repeat (4) tick();
    rs_req = '0;
    repeat (4) tick();
    chk("end_occ", 64'(occupancy), 64'(2'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
